audio_tone_prescaler: RTL and testbench

// - Sits directly downstream of the tone decoder. Consumes its 10-bit preScaleValue; one tone period is 256*preScaleValue clk cycles.
// - Divides clk by preScaleValue to make a sample tick. Advances an 8-bit phase accumulator on each tick.
// - Outputs the phase, a square wave and an 8-bit sample for the audio DAC stage.
// - Frequency changes and stops take effect only on a phase wrap, which gives click-free note transitions.

---
 rtl/audio_tone_prescaler_if.sv | 37 +++
 rtl/audio_tone_prescaler.sv | 138 +++++++++++++
 tb/tb_audio_tone_prescaler.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/audio_tone_prescaler_if.sv
// Tone-request / audio-output bundle between the tone decoder, the prescaler and the DAC stage.
// The master side is the tone decoder. The slave side is audio_tone_prescaler.
interface audio_tone_prescaler_if #(
  parameter int unsigned PHASE_W = 8,
  parameter int unsigned PRESC_W = 10
);
  logic               enable;
  logic [PRESC_W-1:0] preScaleValue;
  logic               sample_tick;
  logic               period_done;
  logic [PHASE_W-1:0] phase;
  logic               square_out;
  logic [7:0]         sample_out;
  logic               busy;

  modport master (
    output enable,
    output preScaleValue,
    input  sample_tick,
    input  period_done,
    input  phase,
    input  square_out,
    input  sample_out,
    input  busy
  );

  modport slave (
    input  enable,
    input  preScaleValue,
    output sample_tick,
    output period_done,
    output phase,
    output square_out,
    output sample_out,
    output busy
  );
endinterface

// File: rtl/audio_tone_prescaler.sv
// Sample-tick divider and 8-bit phase accumulator; retunes and stops only on a phase wrap.
// Optional macro TONE_SINE_EN: quarter-wave sine sample_out instead of the square-wave sample_out.
module audio_tone_prescaler #(
  parameter int unsigned PHASE_W = 8,
  parameter int unsigned PRESC_W = 10
) (
  input logic                   clk,
  input logic                   resetN,
  audio_tone_prescaler_if.slave tone_io
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] div_cnt_q, div_cnt_d;
  logic [PRESC_W-1:0] presc_lat_q, presc_lat_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
  logic               tick_hit, wrap, busy;

  assign busy     = (state_q != StIdle);
  assign tick_hit = (div_cnt_q == presc_lat_q - PRESC_W'(1));
  assign wrap     = tick_hit && (phase_q == '1);

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    presc_lat_d = presc_lat_q;
    phase_d     = phase_q;
    tick_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (tone_io.enable && (tone_io.preScaleValue != '0)) begin
          state_d     = StRun;
          presc_lat_d = tone_io.preScaleValue;
          div_cnt_d   = '0;
          phase_d     = '0;
        end
      end
      StRun, StDrain: begin
        if ((state_q == StRun) && !tone_io.enable) begin
          state_d = StDrain;
        end else if ((state_q == StDrain) && tone_io.enable) begin
          state_d = StRun;
        end
        if (tick_hit) begin
          div_cnt_d = '0;
          phase_d   = phase_q + PHASE_W'(1);
          tick_d    = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + PRESC_W'(1);
        end
        // A wrap is the only point where the period may change or the tone may stop.
        // A re-raised enable during DRAIN wins over the stop on that wrap.
        if (wrap) begin
          done_d      = 1'b1;
          presc_lat_d = tone_io.preScaleValue;
          if ((tone_io.preScaleValue == '0) || ((state_q == StDrain) && !tone_io.enable)) begin
            state_d     = StIdle;
            div_cnt_d   = '0;
            presc_lat_d = '0;
            phase_d     = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= StIdle;
      div_cnt_q   <= '0;
      presc_lat_q <= '0;
      phase_q     <= '0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      presc_lat_q <= presc_lat_d;
      phase_q     <= phase_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
    end
  end

  assign tone_io.sample_tick = tick_q;
  assign tone_io.period_done = done_q;
  assign tone_io.phase       = phase_q;
  assign tone_io.busy        = busy;
  assign tone_io.square_out  = phase_q[PHASE_W-1] & busy;

`ifdef TONE_SINE_EN
  // round(127*sin(pi*i/128)); the other three quadrants come from mirroring and negation.
  localparam logic [6:0] SineRom [64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
  };

  logic [7:0] sample_q, sample_d;
  logic [5:0] rom_idx;
  logic [6:0] rom_mag;

  always_comb begin
    rom_idx = phase_q[6] ? ~phase_q[5:0] : phase_q[5:0];
    rom_mag = SineRom[rom_idx];
    if (!busy) begin
      sample_d = 8'h80;
    end else if (phase_q[7]) begin
      sample_d = 8'h80 - {1'b0, rom_mag};
    end else begin
      sample_d = 8'h80 + {1'b0, rom_mag};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      sample_q <= 8'h80;
    end else begin
      sample_q <= sample_d;
    end
  end

  assign tone_io.sample_out = sample_q;
`else
  assign tone_io.sample_out = {8{tone_io.square_out}};
`endif

endmodule

// File: tb/tb_audio_tone_prescaler.sv
// Randomised scoreboard bench for audio_tone_prescaler: a time-based tone model predicts every
// cycle's outputs into a queue and a separate monitor pops and compares them.
module tb_audio_tone_prescaler;

  typedef struct packed {
    logic       tick;
    logic       done;
    logic       busy;
    logic       square;
    logic [7:0] phase;
    logic [7:0] sample;
    logic       s_chk;
    logic [1:0] s_tol;
  } exp_t;

  logic clk = 1'b0;
  logic resetN = 1'b0;

  audio_tone_prescaler_if tone_if ();

  audio_tone_prescaler dut (
    .clk     (clk),
    .resetN  (resetN),
    .tone_io (tone_if)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Model: a tone is a period start time plus a prescale; everything else is arithmetic on the
  // number of cycles elapsed since that start. Mode 0 = silent, 1 = playing, 2 = draining.
  int          m_mode = 0;
  int unsigned m_presc = 0;
  int unsigned m_elapsed = 0;
  bit          m_busy_prev = 1'b0;
  int          m_phase_prev = 0;

  task automatic step(input bit rst, input bit en, input int unsigned psv);
    exp_t e;
    int   ph;
    bit   tick, done, was_drain;
    logic [9:0] psv10;
    psv10 = psv[9:0];
    @(negedge clk);
    resetN                = rst;
    tone_if.enable        = en;
    tone_if.preScaleValue = psv10;
    ph   = 0;
    tick = 1'b0;
    done = 1'b0;
    e    = '0;
`ifdef TONE_SINE_EN
    // Sine output lags the phase by one cycle; only the four cardinal phases are pinned down.
    e.s_chk = 1'b1;
    e.sample = 8'h80;
    if (rst && m_busy_prev) begin
      case (m_phase_prev)
        0, 128:  e.sample = 8'h80;
        64:      begin e.sample = 8'hFF; e.s_tol = 2'd1; end
        192:     begin e.sample = 8'h00; e.s_tol = 2'd1; end
        default: e.s_chk = 1'b0;
      endcase
    end
`endif
    if (!rst) begin
      m_mode = 0;
      m_presc = 0;
      m_elapsed = 0;
    end else if (m_mode == 0) begin
      if (en && psv10 != 0) begin
        m_mode = 1;
        m_presc = psv10;
        m_elapsed = 0;
      end
    end else begin
      was_drain = (m_mode == 2);
      m_elapsed++;
      tick = (m_elapsed % m_presc) == 0;
      ph   = (m_elapsed / m_presc) % 256;
      if (m_mode == 1 && !en) m_mode = 2;
      else if (m_mode == 2 && en) m_mode = 1;
      if (m_elapsed == 256 * m_presc) begin
        done = 1'b1;
        m_elapsed = 0;
        m_presc = psv10;
        if (psv10 == 0 || (was_drain && !en)) begin
          m_mode = 0;
          m_presc = 0;
        end
      end
    end
    e.tick   = tick;
    e.done   = done;
    e.busy   = (m_mode != 0);
    e.phase  = e.busy ? 8'(ph) : 8'h00;
    e.square = e.busy && (e.phase >= 8'd128);
`ifndef TONE_SINE_EN
    e.s_chk  = 1'b1;
    e.sample = e.square ? 8'hFF : 8'h00;
`endif
    m_busy_prev  = e.busy;
    m_phase_prev = int'(e.phase);
    sb_q.push_back(e);
  endtask

  task automatic run(input bit en, input int unsigned psv, input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, en, psv);
  endtask

  // Monitor: one expected record per clock edge, compared 1 ns after that edge.
  initial begin : monitor
    exp_t e;
    int   mcyc;
    int   diff;
    bit   ok;
    mcyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        diff = int'(tone_if.sample_out) - int'(e.sample);
        if (diff < 0) diff = -diff;
        ok = (tone_if.sample_tick === e.tick) && (tone_if.period_done === e.done) &&
             (tone_if.busy === e.busy) && (tone_if.square_out === e.square) &&
             (tone_if.phase === e.phase) &&
             (!e.s_chk || (!$isunknown(tone_if.sample_out) && diff <= int'(e.s_tol)));
        n_checks++;
        if (!ok) begin
          n_errors++;
          $display("FAIL cycle %0d: got tick=%b done=%b busy=%b sq=%b phase=%02h sample=%02h, want tick=%b done=%b busy=%b sq=%b phase=%02h sample=%02h(chk=%b tol=%0d)",
                   mcyc, tone_if.sample_tick, tone_if.period_done, tone_if.busy,
                   tone_if.square_out, tone_if.phase, tone_if.sample_out, e.tick, e.done,
                   e.busy, e.square, e.phase, e.sample, e.s_chk, e.s_tol);
        end
        mcyc++;
      end
    end
  end

  initial begin : stimulus
    int unsigned psv;
    int          len;
    bit          en;
    tone_if.enable = 1'b0;
    tone_if.preScaleValue = '0;

    // Reset held with a live tone request must keep everything quiet.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 10'h1D6);
    // Zero prescale from silence is a mute.
    run(1'b1, 0, 20);
    // Fastest legal rate, then drain to the wrap.
    run(1'b1, 1, 600);
    run(1'b0, 1, 300);
    // Retune mid-period: old spacing holds until the wrap.
    run(1'b1, 5, 700);
    run(1'b1, 3, 2000);
    run(1'b0, 3, 1000);
    // Drain then re-raise enable before the wrap: no restart.
    run(1'b1, 2, 200);
    run(1'b0, 2, 100);
    run(1'b1, 2, 300);
    run(1'b0, 2, 600);
    // Slow real-world tone, aborted by a reset mid-period.
    run(1'b1, 10'h1D6, 3000);
    step(1'b0, 1'b1, 10'h1D6);
    run(1'b0, 0, 5);

    for (int s = 0; s < 40; s++) begin
      len = $urandom_range(50, 1500);
      en  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       psv = 0;
        1:       psv = 1;
        default: psv = $urandom_range(2, 9);
      endcase
      if ($urandom_range(0, 14) == 0) begin
        step(1'b0, en, psv);
        step(1'b0, en, psv);
      end
      for (int i = 0; i < len; i++) begin
        // Occasional mid-period prescale wobble; only the value at a wrap may take effect.
        if ($urandom_range(0, 199) == 0) psv = $urandom_range(1, 9);
        step(1'b1, en, psv);
      end
    end

    run(1'b0, 0, 3);
    @(posedge clk);
    #3;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
